// File: rtl/sdu_tx_arbiter.sv
// Message-granular arbiter sharing one uart_tx byte channel between two
// requesters (A: debug replies, B: print/echo), with a stall timeout.
module sdu_tx_arbiter #(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] d_a,
   input  logic       vld_a,
   output logic       rdy_a,
   input  logic       last_a,
   input  logic [7:0] d_b,
   input  logic       vld_b,
   output logic       rdy_b,
   input  logic       last_b,
   output logic [7:0] d_tx,
   output logic       vld_tx,
   input  logic       rdy_tx,
   output logic [1:0] grant,
   output logic       timeout
);

   // Handshake: a byte moves on any port only in a cycle where its valid and
   // ready are both high; valid and data never depend on the same port's ready.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      GNT_A = 2'b01,
      GNT_B = 2'b10
   } state_e;

   localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic        last_served_q, last_served_d;
   logic [7:0]  d_tx_q, d_tx_d;
   logic        vld_tx_q, vld_tx_d;
   logic [15:0] stall_q, stall_d;
   logic        timeout_q, timeout_d;

   logic        own_a;
   logic        own_b;
   logic        out_free;
   logic        own_vld;
   logic [7:0]  own_d;
   logic        own_last;
   logic        accept;
   logic        stall_hit;

   assign own_a     = (state_q == GNT_A);
   assign own_b     = (state_q == GNT_B);
   assign out_free  = !vld_tx_q || rdy_tx;
   assign rdy_a     = own_a && out_free;
   assign rdy_b     = own_b && out_free;
   assign own_vld   = (own_a && vld_a) || (own_b && vld_b);
   assign own_d     = own_a ? d_a : d_b;
   assign own_last  = own_a ? last_a : last_b;
   assign accept    = own_vld && out_free;
   assign stall_hit = (stall_q == STALL_LIMIT);

   // Output holding register: a new byte and a drain in the same cycle keep
   // vld_tx high so a streaming owner gets one byte per cycle.
   always_comb begin
      d_tx_d   = d_tx_q;
      vld_tx_d = vld_tx_q;
      if (accept) begin
         d_tx_d   = own_d;
         vld_tx_d = 1'b1;
      end else if (vld_tx_q && rdy_tx) begin
         vld_tx_d = 1'b0;
      end
   end

   // last_served: 1 means B was served last, so A wins the next tie.
   always_comb begin
      state_d       = state_q;
      last_served_d = last_served_q;
      stall_d       = stall_q;
      timeout_d     = 1'b0;
      case (state_q)
         IDLE: begin
            stall_d = '0;
            if (vld_a && (!vld_b || last_served_q)) begin
               state_d = GNT_A;
            end else if (vld_b) begin
               state_d = GNT_B;
            end
         end
         GNT_A, GNT_B: begin
            if (accept) begin
               stall_d = '0;
               if (own_last) begin
                  state_d       = IDLE;
                  last_served_d = own_b;
               end
            end else if (!own_vld) begin
               // Only an absent owner counts as a stall; downstream backpressure does not.
               if (stall_hit) begin
                  state_d       = IDLE;
                  last_served_d = own_b;
                  timeout_d     = 1'b1;
                  stall_d       = '0;
               end else if (stall_q != 16'hFFFF) begin
                  stall_d = stall_q + 16'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         last_served_q <= 1'b1;
         d_tx_q        <= 8'h00;
         vld_tx_q      <= 1'b0;
         stall_q       <= '0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_served_q <= last_served_d;
         d_tx_q        <= d_tx_d;
         vld_tx_q      <= vld_tx_d;
         stall_q       <= stall_d;
         timeout_q     <= timeout_d;
      end
   end

   // grant is the state register itself, so it doubles as the FSM debug view.
   assign grant   = state_q;
   assign d_tx    = d_tx_q;
   assign vld_tx  = vld_tx_q;
   assign timeout = timeout_q;

endmodule

// File: tb/tb_sdu_tx_arbiter.sv
// Directed bench for sdu_tx_arbiter: queue-backed requesters, a transfer
// monitor on the uart side, and per-scenario tasks with hand-computed results.
`timescale 1ns/1ps
module tb_sdu_tx_arbiter;

   localparam int TO = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] d_a, d_b, d_tx;
   logic       vld_a, vld_b, rdy_a, rdy_b, last_a, last_b;
   logic       vld_tx, rdy_tx, timeout;
   logic [1:0] grant;

   int checks = 0;
   int failures = 0;

   logic [7:0] a_q[$];
   logic [7:0] b_q[$];
   logic       al_q[$];
   logic       bl_q[$];
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];
   int         xfer_cyc_q[$];

   int          cyc = 0;
   int          rdy_mode = 0;
   int          to_cnt = 0;
   int          to_cyc = -1;
   int          acc_a_cyc = -1;
   int          stab_err = 0;
   int          xrdy_err = 0;
   logic        hold_pending = 1'b0;
   logic [7:0]  hold_d = 8'h00;
   logic [31:0] gh_word = 32'h0;
   logic [1:0]  gh_last = 2'b11;
   int          gh_n = 0;

   sdu_tx_arbiter #(.TIMEOUT(TO)) dut (
      .clk     (clk),
      .rst     (rst),
      .d_a     (d_a),
      .vld_a   (vld_a),
      .rdy_a   (rdy_a),
      .last_a  (last_a),
      .d_b     (d_b),
      .vld_b   (vld_b),
      .rdy_b   (rdy_b),
      .last_b  (last_b),
      .d_tx    (d_tx),
      .vld_tx  (vld_tx),
      .rdy_tx  (rdy_tx),
      .grant   (grant),
      .timeout (timeout)
   );

   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic drive();
      vld_a  = (a_q.size() != 0);
      d_a    = vld_a ? a_q[0] : 8'h00;
      last_a = vld_a ? al_q[0] : 1'b0;
      vld_b  = (b_q.size() != 0);
      d_b    = vld_b ? b_q[0] : 8'h00;
      last_b = vld_b ? bl_q[0] : 1'b0;
      case (rdy_mode)
         0:       rdy_tx = 1'b1;
         1:       rdy_tx = (cyc % 2 == 0);
         default: rdy_tx = 1'b0;
      endcase
   endtask

   task automatic clear_obs();
      got_q.delete();
      xfer_cyc_q.delete();
      to_cnt       = 0;
      to_cyc       = -1;
      acc_a_cyc    = -1;
      hold_pending = 1'b0;
      gh_word      = 32'h0;
      gh_last      = 2'b11;
      gh_n         = 0;
   endtask

   // One cycle: observe at the falling edge, then update sources after the rising edge.
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (hold_pending && (!vld_tx || d_tx !== hold_d)) stab_err++;
      hold_pending = vld_tx && !rdy_tx;
      hold_d       = d_tx;
      if ((rdy_a && grant !== 2'b01) || (rdy_b && grant !== 2'b10)) xrdy_err++;
      if (vld_tx && rdy_tx) begin
         got_q.push_back(d_tx);
         xfer_cyc_q.push_back(cyc);
      end
      if (timeout) begin
         to_cnt++;
         if (to_cyc < 0) to_cyc = cyc;
      end
      if (grant !== gh_last) begin
         gh_word = (gh_word << 2) | 32'(grant);
         gh_last = grant;
         gh_n++;
      end
      if (vld_a && rdy_a) begin
         acc_a_cyc = cyc;
         void'(a_q.pop_front());
         void'(al_q.pop_front());
      end
      if (vld_b && rdy_b) begin
         void'(b_q.pop_front());
         void'(bl_q.pop_front());
      end
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive();
      repeat (2) @(posedge clk);
      #1;
      clear_obs();
      rst = 1'b1;
      drive();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      a_q = '{8'h11}; al_q = '{1'b1};
      b_q = '{8'h22}; bl_q = '{1'b1};
      rdy_mode = 0;
      rst = 1'b0;
      drive();
      repeat (2) @(negedge clk);
      checks++; if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant: got %b expected 00", grant); end
      checks++; if (vld_tx !== 1'b0) begin failures++; $display("FAIL reset_vld_tx: got %b expected 0", vld_tx); end
      checks++; if (d_tx !== 8'h00) begin failures++; $display("FAIL reset_d_tx: got %02h expected 00", d_tx); end
      checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
      checks++; if (rdy_a !== 1'b0) begin failures++; $display("FAIL reset_rdy_a: got %b expected 0", rdy_a); end
      checks++; if (rdy_b !== 1'b0) begin failures++; $display("FAIL reset_rdy_b: got %b expected 0", rdy_b); end
   endtask

   task automatic test_round_robin();
      a_q = '{8'h41, 8'h42, 8'h43, 8'h44}; al_q = '{1'b0, 1'b0, 1'b1, 1'b1};
      b_q = '{8'h61, 8'h62};               bl_q = '{1'b0, 1'b1};
      rdy_mode = 0;
      do_reset();
      repeat (25) tick();
      exp_q = '{8'h41, 8'h42, 8'h43, 8'h61, 8'h62, 8'h44};
      checks++;
      if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rr_count: got %0d bytes expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rr_byte%0d: got %02h expected %02h", i, got_q[i], exp_q[i]); end
      end
      // 00,01,00,10,00,01,00 packed two bits per grant change
      checks++;
      if (gh_word !== 32'h484 || gh_n != 7) begin failures++; $display("FAIL rr_grant_seq: got %h/%0d expected 484/7", gh_word, gh_n); end
   endtask

   task automatic test_backpressure();
      a_q = '{8'h4F, 8'h4B, 8'h0A}; al_q = '{1'b0, 1'b0, 1'b1};
      b_q.delete(); bl_q.delete();
      rdy_mode = 1;
      do_reset();
      repeat (16) tick();
      exp_q = '{8'h4F, 8'h4B, 8'h0A};
      checks++;
      if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL bp_count: got %0d bytes expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_byte%0d: got %02h expected %02h", i, got_q[i], exp_q[i]); end
      end
      checks++;
      if (stab_err != 0) begin failures++; $display("FAIL bp_stable: got %0d unstable holds expected 0", stab_err); end
   endtask

   task automatic test_timeout();
      a_q = '{8'h55};        al_q = '{1'b0};
      b_q = '{8'h71, 8'h72}; bl_q = '{1'b0, 1'b1};
      rdy_mode = 0;
      do_reset();
      repeat (30) tick();
      // acceptance edge follows the sampling negedge; pulse is seen 8 edges later
      checks++;
      if (to_cyc - acc_a_cyc != TO + 1) begin failures++; $display("FAIL to_latency: got %0d expected %0d", to_cyc - acc_a_cyc, TO + 1); end
      checks++;
      if (to_cnt != 1) begin failures++; $display("FAIL to_pulse_width: got %0d cycles expected 1", to_cnt); end
      exp_q = '{8'h55, 8'h71, 8'h72};
      checks++;
      if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL to_count: got %0d bytes expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL to_byte%0d: got %02h expected %02h", i, got_q[i], exp_q[i]); end
      end
      checks++;
      if (gh_word !== 32'h48 || gh_n != 5) begin failures++; $display("FAIL to_grant_seq: got %h/%0d expected 48/5", gh_word, gh_n); end
   endtask

   task automatic test_back_to_back();
      a_q.delete(); al_q.delete();
      for (int i = 0; i < 8; i++) begin
         a_q.push_back(8'hA0 + 8'(i));
         al_q.push_back(i == 7);
      end
      b_q.delete(); bl_q.delete();
      rdy_mode = 0;
      do_reset();
      repeat (16) tick();
      exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
      checks++;
      if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b_count: got %0d bytes expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_byte%0d: got %02h expected %02h", i, got_q[i], exp_q[i]); end
      end
      checks++;
      if (xfer_cyc_q.size() < 8 || xfer_cyc_q[7] - xfer_cyc_q[0] != 7) begin
         failures++;
         $display("FAIL b2b_rate: got %0d transfers, span %0d cycles expected 8 in 7",
                  xfer_cyc_q.size(), (xfer_cyc_q.size() >= 8) ? xfer_cyc_q[7] - xfer_cyc_q[0] : -1);
      end
   endtask

   task automatic test_reset_mid();
      a_q.delete(); al_q.delete();
      b_q = '{8'h81, 8'h82, 8'h83}; bl_q = '{1'b0, 1'b0, 1'b0};
      rdy_mode = 2;
      do_reset();
      repeat (4) tick();
      checks++;
      if (vld_tx !== 1'b1 || grant !== 2'b10) begin failures++; $display("FAIL rm_pre: got vld_tx=%b grant=%b expected 1/10", vld_tx, grant); end
      rst = 1'b0;
      #1;
      checks++; if (vld_tx !== 1'b0) begin failures++; $display("FAIL rm_vld_tx: got %b expected 0", vld_tx); end
      checks++; if (grant !== 2'b00) begin failures++; $display("FAIL rm_grant: got %b expected 00", grant); end
      checks++; if (d_tx !== 8'h00) begin failures++; $display("FAIL rm_d_tx: got %02h expected 00", d_tx); end
      a_q = '{8'h91}; al_q = '{1'b1};
      b_q = '{8'h85}; bl_q = '{1'b1};
      rdy_mode = 0;
      drive();
      @(posedge clk);
      #1;
      clear_obs();
      rst = 1'b1;
      drive();
      repeat (12) tick();
      exp_q = '{8'h91, 8'h85};
      checks++;
      if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rm_count: got %0d bytes expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rm_byte%0d: got %02h expected %02h", i, got_q[i], exp_q[i]); end
      end
      checks++;
      if (gh_word !== 32'h48 || gh_n != 5) begin failures++; $display("FAIL rm_grant_seq: got %h/%0d expected 48/5", gh_word, gh_n); end
   endtask

   task automatic test_no_timeout_backpressure();
      a_q.delete(); al_q.delete();
      b_q = '{8'hB1, 8'hB2, 8'hB3}; bl_q = '{1'b0, 1'b0, 1'b1};
      rdy_mode = 2;
      do_reset();
      repeat (2 * TO + 4) tick();
      checks++; if (to_cnt != 0) begin failures++; $display("FAIL nbp_timeout: got %0d pulses expected 0", to_cnt); end
      checks++; if (grant !== 2'b10) begin failures++; $display("FAIL nbp_grant: got %b expected 10", grant); end
      rdy_mode = 0;
      drive();
      repeat (10) tick();
      exp_q = '{8'hB1, 8'hB2, 8'hB3};
      checks++;
      if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL nbp_count: got %0d bytes expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL nbp_byte%0d: got %02h expected %02h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (grant !== 2'b00) begin failures++; $display("FAIL nbp_grant_end: got %b expected 00", grant); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst = 1'b0;
      drive();
      test_reset();
      test_round_robin();
      test_backpressure();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      test_no_timeout_backpressure();
      checks++;
      if (stab_err != 0) begin failures++; $display("FAIL hold_stability: got %0d unstable holds expected 0", stab_err); end
      checks++;
      if (xrdy_err != 0) begin failures++; $display("FAIL foreign_ready: got %0d cycles expected 0", xrdy_err); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
